// File: rtl/gemm_pkg.sv
// -----------------------------------------------------------------------------
// gemm_pkg
// Shared types and default sizing for the GEMM tile-pass sequencer.
//   state_e          : sequencer states IDLE/LOAD/EXEC/FLUSH/DRAIN
//   *_DEF constants  : default buffer depths and data width
//   *_AW_DEF         : matching address widths
// -----------------------------------------------------------------------------
package gemm_pkg;

  localparam int SRC_DEPTH_DEF = 32;
  localparam int DST_DEPTH_DEF = 16;
  localparam int DW_DEF        = 32;

  localparam int SRC_AW_DEF = $clog2(SRC_DEPTH_DEF);
  localparam int DST_AW_DEF = $clog2(DST_DEPTH_DEF);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EXEC  = 3'd2,
    FLUSH = 3'd3,
    DRAIN = 3'd4
  } state_e;

endpackage

// File: rtl/gemm_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// gemm_seq_ctrl_if
// Bundle of every control/data pin between the sequencer and its environment
// (host streams, src_buf, MAC datapath, dst_buf).
//   slave  modport : the sequencer (gemm_seq_ctrl)
//   master modport : the environment driving start / streams / dst read data
// Optional macro GEMM_SEQ_CTRL_PERF_EN adds the perf_cycles[31:0] signal.
// -----------------------------------------------------------------------------
interface gemm_seq_ctrl_if #(
  parameter int SRC_DEPTH = 32,
  parameter int DST_DEPTH = 16,
  parameter int DW        = 32
);
  localparam int SRC_AW = $clog2(SRC_DEPTH);
  localparam int DST_AW = $clog2(DST_DEPTH);

  logic              start;
  logic              busy;
  logic              done;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_data;
  logic              src_v;
  logic [SRC_AW-1:0] src_a;
  logic [DW-1:0]     src_d;
  logic              exec;
  logic [SRC_AW-1:0] ia;
  logic              mac_en;
  logic              mac_first;
  logic              outr;
  logic [DST_AW-1:0] oa;
  logic              dst_v;
  logic [DST_AW-1:0] dst_a;
  logic [DW-1:0]     dst_d;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
`ifdef GEMM_SEQ_CTRL_PERF_EN
  logic [31:0]       perf_cycles;
`endif

  modport slave (
`ifdef GEMM_SEQ_CTRL_PERF_EN
    output perf_cycles,
`endif
    input  start, in_valid, in_data, dst_d, out_ready,
    output busy, done, in_ready, src_v, src_a, src_d, exec, ia,
           mac_en, mac_first, outr, oa, dst_v, dst_a, out_valid, out_data
  );

  modport master (
`ifdef GEMM_SEQ_CTRL_PERF_EN
    input  perf_cycles,
`endif
    output start, in_valid, in_data, dst_d, out_ready,
    input  busy, done, in_ready, src_v, src_a, src_d, exec, ia,
           mac_en, mac_first, outr, oa, dst_v, dst_a, out_valid, out_data
  );

endinterface

// File: rtl/gemm_drain_ctl.sv
// -----------------------------------------------------------------------------
// gemm_drain_ctl
// Drain handshake: issues dst_buf reads and holds out_valid until accepted.
// At most one word is in flight; a new read is issued in the same cycle the
// held word is accepted, giving one word per cycle with out_ready high.
//   clk, rst_n      : clock, async active-low reset
//   active_i        : sequencer is in DRAIN; counters clear while low
//   out_ready_i     : result stream ready
//   dst_v_o/dst_a_o : dst_buf read enable / address
//   out_valid_o     : result stream valid
//   last_accept_o   : accept of the final word of the pass
// -----------------------------------------------------------------------------
module gemm_drain_ctl #(
  parameter int DST_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         active_i,
  input  logic                         out_ready_i,
  output logic                         dst_v_o,
  output logic [$clog2(DST_DEPTH)-1:0] dst_a_o,
  output logic                         out_valid_o,
  output logic                         last_accept_o
);
  localparam int AW = $clog2(DST_DEPTH);
  localparam logic [AW:0]   ISSUE_END = (AW+1)'(DST_DEPTH);
  localparam logic [AW-1:0] LAST_WORD = AW'(DST_DEPTH - 1);

  logic [AW:0]   issue_cnt_q, issue_cnt_d;
  logic [AW-1:0] acc_cnt_q, acc_cnt_d;
  logic          out_valid_q, out_valid_d;
  logic          issue, accept;

  // One extra counter bit so "all words issued" is distinguishable from 0.
  assign issue  = active_i && (!out_valid_q || out_ready_i) && (issue_cnt_q < ISSUE_END);
  assign accept = out_valid_q && out_ready_i;

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    acc_cnt_d   = acc_cnt_q;
    out_valid_d = out_valid_q;
    if (!active_i) begin
      issue_cnt_d = '0;
      acc_cnt_d   = '0;
      out_valid_d = 1'b0;
    end else begin
      if (issue)  issue_cnt_d = issue_cnt_q + 1'b1;
      if (accept) acc_cnt_d   = acc_cnt_q + 1'b1;
      // A fresh issue keeps valid high (back-to-back); otherwise an accept drops it.
      if (issue)       out_valid_d = 1'b1;
      else if (accept) out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q <= '0;
      acc_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      acc_cnt_q   <= acc_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign dst_v_o       = issue;
  assign dst_a_o       = issue_cnt_q[AW-1:0];
  assign out_valid_o   = out_valid_q;
  assign last_accept_o = active_i && accept && (acc_cnt_q == LAST_WORD);

endmodule

// File: rtl/gemm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// gemm_seq_ctrl
// Sequencer for one GEMM tile pass: LOAD the source buffer from the operand
// stream, EXEC a full source-buffer walk through the MAC (K words per result),
// FLUSH the 2-cycle MAC pipeline, then DRAIN the destination buffer.
//   clk, rst_n : clock, async active-low reset
//   bus        : gemm_seq_ctrl_if.slave -- start/busy/done, operand stream,
//                src_buf write, MAC control, dst_buf read, result stream
// Optional macro GEMM_SEQ_CTRL_PERF_EN: adds bus.perf_cycles, a saturating
// count of busy cycles in the most recent pass.
// -----------------------------------------------------------------------------
module gemm_seq_ctrl
  import gemm_pkg::*;
#(
  parameter int SRC_DEPTH = SRC_DEPTH_DEF,
  parameter int DST_DEPTH = DST_DEPTH_DEF,
  parameter int DW        = DW_DEF
) (
  input logic            clk,
  input logic            rst_n,
  gemm_seq_ctrl_if.slave bus
);
  localparam int SRC_AW = $clog2(SRC_DEPTH);
  localparam int DST_AW = $clog2(DST_DEPTH);
  localparam int K      = SRC_DEPTH / DST_DEPTH;
  localparam logic [SRC_AW-1:0] SRC_LAST = SRC_AW'(SRC_DEPTH - 1);

  state_e            state_q, state_d;
  logic [SRC_AW-1:0] cnt_q, cnt_d;
  logic              in_acc;
  logic              drain_last;

  // MAC pipeline: src read data arrives one cycle after exec.
  logic              mac_en_q;
  logic [SRC_AW-1:0] ia_q;
  logic              outr_q, outr_d;
  logic [DST_AW-1:0] oa_q;
  logic              done_q;

  assign in_acc = bus.in_valid && (state_q == LOAD);

  // NOTE: every combinational output is given a default before the case, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (bus.start) begin
        state_d = LOAD;
        cnt_d   = '0;
      end
      LOAD: if (in_acc) begin
        if (cnt_q == SRC_LAST) begin
          state_d = EXEC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EXEC: begin
        if (cnt_q == SRC_LAST) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // Two cycles: the last mac_en, then the last outr.
      FLUSH: begin
        if (cnt_q == SRC_AW'(1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: if (drain_last) state_d = IDLE;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign outr_d = mac_en_q && ((int'(ia_q) % K) == K - 1);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mac_en_q <= 1'b0;
      ia_q     <= '0;
      outr_q   <= 1'b0;
      oa_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mac_en_q <= (state_q == EXEC);
      ia_q     <= cnt_q;
      outr_q   <= outr_d;
      if (outr_d) oa_q <= DST_AW'(int'(ia_q) / K);
      // done lands in the first IDLE cycle, together with busy falling.
      done_q   <= drain_last;
    end
  end

  gemm_drain_ctl #(
    .DST_DEPTH (DST_DEPTH)
  ) u_drain (
    .clk           (clk),
    .rst_n         (rst_n),
    .active_i      (state_q == DRAIN),
    .out_ready_i   (bus.out_ready),
    .dst_v_o       (bus.dst_v),
    .dst_a_o       (bus.dst_a),
    .out_valid_o   (bus.out_valid),
    .last_accept_o (drain_last)
  );

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.in_ready  = (state_q == LOAD);
  assign bus.src_v     = in_acc;
  assign bus.src_a     = cnt_q;
  assign bus.src_d     = bus.in_data;
  assign bus.exec      = (state_q == EXEC);
  assign bus.ia        = cnt_q;
  assign bus.mac_en    = mac_en_q;
  assign bus.mac_first = mac_en_q && ((int'(ia_q) % K) == 0);
  assign bus.outr      = outr_q;
  assign bus.oa        = oa_q;
  assign bus.out_data  = bus.dst_d;

`ifdef GEMM_SEQ_CTRL_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (state_q == IDLE && bus.start) begin
      perf_q <= '0;
    end else if (state_q != IDLE && perf_q != '1) begin
      perf_q <= perf_q + 1'b1;
    end
  end

  assign bus.perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_gemm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gemm_seq_ctrl
// Directed bench for gemm_seq_ctrl. A per-cycle monitor derives every expected
// output from pass-level bookkeeping (words loaded, exec start cycle T, words
// issued/accepted); directed passes add literal timing/count expectations.
// -----------------------------------------------------------------------------
module tb_gemm_seq_ctrl;
  localparam int SD = 32;
  localparam int DD = 16;
  localparam int KK = SD / DD;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  gemm_seq_ctrl_if #(.SRC_DEPTH(SD), .DST_DEPTH(DD), .DW(32)) bus ();

  gemm_seq_ctrl #(.SRC_DEPTH(SD), .DST_DEPTH(DD), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // dst_buf model: registered read, output holds while not read.
  logic [31:0] mem [DD];
  always @(posedge clk) if (bus.dst_v) bus.dst_d <= mem[bus.dst_a];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ld_word(input logic [31:0] salt, input int i);
    return salt ^ (32'(i) * 32'h0101_0101);
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] salt, input int i);
    return salt + 32'h100 + 32'(i) * 32'd7;
  endfunction

  logic [31:0] cur_salt = 32'h0;

  // ---------------- monitor / model ----------------
  int  cyc = 0;
  bit  m_busy = 0;
  int  load_idx = 0, exec_idx = 0, issue_idx = 0, acc_idx = 0;
  int  t_exec = -1, final_cyc = -10;
  int  n_src, n_outr, n_acc, n_stall, last_src_cyc, first_outr_off, first_acc_cyc, last_acc_cyc;
  bit  stalled = 0;
  logic [31:0] stall_data;
  bit  ir_exp, ex_exp, me_exp, mf_exp, or_exp, in_drain, ov_exp, dv_exp, finish_pass;
  int  dd, gg;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      check("reset_outputs",
            {bus.busy, bus.done, bus.in_ready, bus.src_v, bus.exec, bus.mac_en, bus.mac_first,
             bus.outr, bus.dst_v, bus.out_valid, bus.src_a, bus.ia, bus.oa, bus.dst_a}, '0);
      m_busy = 0; t_exec = -1; load_idx = 0; exec_idx = 0; issue_idx = 0; acc_idx = 0;
      final_cyc = -10; stalled = 0;
    end else begin
      finish_pass = 0;
      check("busy", bus.busy, m_busy);
      check("done", bus.done, cyc == final_cyc + 1);

      ir_exp = m_busy && load_idx < SD;
      ex_exp = m_busy && load_idx == SD && exec_idx < SD;
      check("in_ready", bus.in_ready, ir_exp);
      check("src_v", bus.src_v, ir_exp && bus.in_valid);
      check("exec", bus.exec, ex_exp);
      check("excl_src_exec", bus.src_v && bus.exec, 1'b0);
      check("excl_outr_dst", bus.outr && bus.dst_v, 1'b0);

      if (bus.src_v && ir_exp) begin
        check("src_a", bus.src_a, load_idx);
        check("src_d", bus.src_d, ld_word(cur_salt, load_idx));
        n_src++; last_src_cyc = cyc; load_idx++;
      end
      if (bus.exec && ex_exp) begin
        check("ia", bus.ia, exec_idx);
        if (exec_idx == 0) t_exec = cyc;
        exec_idx++;
      end

      me_exp = t_exec >= 0 && cyc >= t_exec + 1 && cyc <= t_exec + SD;
      mf_exp = me_exp && ((cyc - t_exec - 1) % KK == 0);
      dd     = cyc - t_exec - 1;
      or_exp = t_exec >= 0 && dd >= KK && (dd % KK == 0) && (dd / KK <= DD);
      gg     = dd / KK - 1;
      check("mac_en", bus.mac_en, me_exp);
      check("mac_first", bus.mac_first, mf_exp);
      check("outr", bus.outr, or_exp);
      if (bus.outr && or_exp) begin
        check("oa", bus.oa, gg);
        n_outr++;
        if (n_outr == 1) first_outr_off = cyc - t_exec;
      end

      // Drain begins after EXEC (SD cycles) and FLUSH (2 cycles).
      in_drain = m_busy && t_exec >= 0 && cyc >= t_exec + SD + 2;
      ov_exp   = in_drain && issue_idx > acc_idx;
      dv_exp   = in_drain && issue_idx < DD && (!ov_exp || bus.out_ready);
      check("out_valid", bus.out_valid, ov_exp);
      check("dst_v", bus.dst_v, dv_exp);
      if (bus.dst_v && dv_exp) begin
        check("dst_a", bus.dst_a, issue_idx);
        issue_idx++;
      end
      if (bus.out_valid && ov_exp) begin
        if (stalled) check("stall_hold", bus.out_data, stall_data);
        if (bus.out_ready) begin
          check("out_data", bus.out_data, mem_word(cur_salt, acc_idx));
          n_acc++;
          if (n_acc == 1) first_acc_cyc = cyc;
          last_acc_cyc = cyc;
          acc_idx++;
          if (acc_idx == DD) begin final_cyc = cyc; finish_pass = 1; end
          stalled = 0;
        end else begin
          stalled = 1; stall_data = bus.out_data; n_stall++;
        end
      end

      if (!m_busy && bus.start) begin
        m_busy = 1; load_idx = 0; exec_idx = 0; issue_idx = 0; acc_idx = 0; t_exec = -1;
        stalled = 0; n_src = 0; n_outr = 0; n_acc = 0; n_stall = 0;
        first_outr_off = -1; first_acc_cyc = -1; last_acc_cyc = -1; last_src_cyc = -1;
      end else if (finish_pass) begin
        m_busy = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic prep_pass(input logic [31:0] salt);
    cur_salt = salt;
    for (int i = 0; i < DD; i++) mem[i] = mem_word(salt, i);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic load_words(input bit gaps, input bit glitch);
    int i = 0;
    int guard = 0;
    while (i < SD && guard < 400) begin
      bus.in_valid = !(gaps && (guard % 3 == 1));
      bus.in_data  = ld_word(cur_salt, i);
      bus.start    = glitch && (guard == 5);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) i++;
      @(posedge clk); #1;
      guard++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    if (i < SD) check("load_timeout", i, SD);
  endtask

  task automatic wait_done(input bit toggle, input bit glitch);
    logic [3:0] pat = 4'b1001;
    bit seen = 0;
    bit glitched = 0;
    bit ov_seen = 0;
    for (int guard = 0; guard < 300 && !seen; guard++) begin
      bus.out_ready = toggle ? pat[guard % 4] : 1'b1;
      bus.start     = glitch && ov_seen && !glitched;
      if (bus.start) glitched = 1;
      @(negedge clk);
      if (bus.out_valid) ov_seen = 1;
      if (bus.done) seen = 1;
      else begin @(posedge clk); #1; end
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    if (!seen) check("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  logic [31:0] perf1;
  bit found;

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", bus.busy, 1'b0);
    @(posedge clk); #1;

    // Pass 1: in_valid held, out_ready held.
    prep_pass(32'hA5A5_0000);
    pulse_start();
    load_words(1'b0, 1'b0);
    wait_done(1'b0, 1'b0);
    check("p1_src_words", n_src, 32);
    check("p1_exec_after_load", t_exec - last_src_cyc, 1);
    check("p1_outr_count", n_outr, 16);
    check("p1_first_outr_T3", first_outr_off, 3);
    check("p1_accepts", n_acc, 16);
    check("p1_drain_span", last_acc_cyc - first_acc_cyc, 15);
    check("p1_first_accept", first_acc_cyc - t_exec, 35);
`ifdef GEMM_SEQ_CTRL_PERF_EN
    perf1 = bus.perf_cycles;
    check("p1_perf", perf1, 83);
`endif

    // Pass 2: input gaps, out_ready 1,0,0,1, ignored start pulses.
    prep_pass(32'h3C3C_1234);
    pulse_start();
    load_words(1'b1, 1'b1);
    wait_done(1'b1, 1'b1);
    check("p2_src_words", n_src, 32);
    check("p2_outr_count", n_outr, 16);
    check("p2_accepts", n_acc, 16);
    check("p2_stalls_seen", n_stall > 0, 1'b1);

    // Pass 3: reset in EXEC at ia=10.
    prep_pass(32'h0F0F_7777);
    pulse_start();
    load_words(1'b0, 1'b0);
    found = 0;
    for (int g = 0; g < 100 && !found; g++) begin
      @(negedge clk);
      if (bus.exec && bus.ia == 5'd10) found = 1;
    end
    check("p3_reached_ia10", found, 1'b1);
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("p3_idle_after_reset", bus.busy, 1'b0);
    @(posedge clk); #1;

    // Pass 4: fresh full pass, identical to pass 1.
    prep_pass(32'hA5A5_0000);
    pulse_start();
    load_words(1'b0, 1'b0);
    wait_done(1'b0, 1'b0);
    check("p4_src_words", n_src, 32);
    check("p4_outr_count", n_outr, 16);
    check("p4_accepts", n_acc, 16);
    check("p4_drain_span", last_acc_cyc - first_acc_cyc, 15);
`ifdef GEMM_SEQ_CTRL_PERF_EN
    check("p4_perf_equal", bus.perf_cycles, perf1);
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gemm_seq_ctrl.md
Name: gemm_seq_ctrl

Overview:
Top-level sequencer for one GEMM tile pass. It streams operands into the source buffer (LOAD), then walks the buffer through the MAC datapath (EXEC) while steering per-group results into the destination buffer. Finally it streams the destination buffer out (DRAIN). It sits between the host valid/ready streams and the src_buf/dst_buf/MAC datapath, and is the only driver of their control pins.

Parameters:
SRC_DEPTH, 32, source buffer words; power of two
DST_DEPTH, 16, destination buffer words; power of two; divides SRC_DEPTH
DW, 32, data word width
K (localparam), SRC_DEPTH/DST_DEPTH, source words accumulated per result (2)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
start  in  1  begin tile pass; sampled only in IDLE
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse when last output word accepted
in_valid  in  1  operand stream valid
in_ready  out  1  operand stream ready
in_data  in  DW  operand word
src_v  out  1  src buffer write enable
src_a  out  log2(SRC_DEPTH)  src write address
src_d  out  DW  src write data (= in_data)
exec  out  1  src buffer read enable
ia  out  log2(SRC_DEPTH)  src read address
mac_en  out  1  MAC accumulate; src data valid this cycle
mac_first  out  1  with mac_en: first word of group, clear accumulator
outr  out  1  dst buffer result write
oa  out  log2(DST_DEPTH)  dst write address / group index
dst_v  out  1  dst buffer read enable
dst_a  out  log2(DST_DEPTH)  dst read address
dst_d  in  DW  dst buffer registered read data
out_valid  out  1  result stream valid
out_ready  in  1  result stream ready
out_data  out  DW  result word (= dst_d)

Behaviour:
- Reset (async, any state): state IDLE; all counters 0; busy, done, in_ready, src_v, exec, mac_en, mac_first, outr, dst_v, out_valid = 0; addresses 0.
- States: IDLE, LOAD, EXEC, FLUSH, DRAIN.
- IDLE: start=1 -> LOAD, cnt=0. start in any other state is ignored.
- LOAD: in_ready=1. Each in_valid&&in_ready: src_v=1 combinationally, src_a=cnt, cnt++. The accept at cnt==SRC_DEPTH-1 -> EXEC, cnt=0. in_valid gaps stall without penalty.
- EXEC: exec=1 every cycle, ia=cnt, cnt=0..SRC_DEPTH-1, no stalls. After ia=SRC_DEPTH-1 -> FLUSH.
- MAC pipeline (fixed 1-cycle src read latency): mac_en = exec delayed 1 cycle. mac_first = mac_en && delayed ia%K==0. outr pulses 1 cycle after the mac_en carrying ia%K==K-1, with oa = that ia/K.
- Timing: with first exec at cycle T, outr for group g fires at T+(g+1)K+1.
- FLUSH: 2 cycles, covering the last mac_en and the last outr, then -> DRAIN, cnt=0.
- DRAIN: dst_v is issued with dst_a=cnt when (!out_valid || out_ready) and cnt<DST_DEPTH; cnt++ on issue. out_valid sets the cycle after dst_v and clears on accept with no new issue. dst_d holds while dst_v=0, so a stalled out_data is stable. Full throughput with out_ready held high.
- Accept of word DST_DEPTH-1: done=1 for one cycle; state -> IDLE; busy falls the same cycle.
- Exclusion: src_v/exec never both high; outr/dst_v never both high. Buffer-internal priority is therefore never exercised.
- Wrap: every counter covers exactly its depth and is cleared on state entry. No address exceeds its depth.

Optional Feature:
GEMM_SEQ_CTRL_PERF_EN
- Defined: adds output perf_cycles[31:0]. It clears on an accepted start, increments every busy cycle, saturates at all-ones, and holds after done until the next start. Reset value 0.
- Undefined: port and counter absent; no other behaviour change.

Decomposition:
- Package gemm_pkg: state enum (IDLE, LOAD, EXEC, FLUSH, DRAIN); default SRC_DEPTH/DST_DEPTH/DW constants; address-width localparams via $clog2.
- One natural sub-module, gemm_drain_ctl: dst_v issue / out_valid hold handshake.

Test Plan:
- Reset then start, 32 words 0..31 with in_valid held -> src_v on 32 consecutive cycles, src_a=0..31; EXEC entered the cycle after.
- EXEC timing -> exec high 32 cycles, ia=0..31; mac_first on mac_en with ia=0,2,..30; outr 16 pulses, oa=0..15, first at T+3, then every 2 cycles.
- DRAIN, out_ready=1 -> out_data = dst_buf[0..15] on 16 consecutive cycles; done on the 16th accept.
- DRAIN with out_ready toggling 1,0,0,1 -> out_data stable while stalled; no word skipped or duplicated; exactly 16 accepts.
- Assert rst_n low in EXEC at ia=10 -> all outputs 0, IDLE next cycle; a fresh full pass then completes correctly.
- start pulsed during LOAD and during DRAIN -> ignored; PERF_EN build reports identical perf_cycles across two identical passes.
